// File: rtl/fpu_req_sequencer.sv
// Issue stage in front of a one-cycle registered fpu: it buffers requests, feeds registered operands
// to the fpu, and returns tagged results in order through a credit-protected result FIFO.
module fpu_req_sequencer #(
  parameter int REQ_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [1:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_op,
  input  logic [31:0]      fpu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [1:0]       inflight
);

  localparam int REQ_AW = (REQ_DEPTH > 2) ? $clog2(REQ_DEPTH) : 1;
  localparam int RES_AW = (RES_DEPTH > 2) ? $clog2(RES_DEPTH) : 1;
  localparam int CRD_W  = RES_AW + 2;
  localparam logic [REQ_AW:0]    REQ_FULL_CNT = (REQ_AW + 1)'(REQ_DEPTH);
  localparam logic [CRD_W-1:0]   RES_CREDITS  = CRD_W'(RES_DEPTH);
  localparam logic [1:0]         OP_DIV       = 2'b11;

  logic                ready_en_r;
  logic [REQ_AW-1:0]   req_wr_ptr_r;
  logic [REQ_AW-1:0]   req_rd_ptr_r;
  logic [REQ_AW:0]     req_count_r;
  logic [31:0]         req_a_mem_r   [REQ_DEPTH];
  logic [31:0]         req_b_mem_r   [REQ_DEPTH];
  logic [1:0]          req_op_mem_r  [REQ_DEPTH];
  logic [TAG_W-1:0]    req_tag_mem_r [REQ_DEPTH];

  logic [RES_AW-1:0]   res_wr_ptr_r;
  logic [RES_AW-1:0]   res_rd_ptr_r;
  logic [RES_AW:0]     res_count_r;
  logic [31:0]         res_data_mem_r [RES_DEPTH];
  logic [TAG_W-1:0]    res_tag_mem_r  [RES_DEPTH];
  logic                res_err_mem_r  [RES_DEPTH];

  logic [31:0]         fpu_a_r;
  logic [31:0]         fpu_b_r;
  logic [1:0]          fpu_op_r;
  logic                s0_valid_r;
  logic [TAG_W-1:0]    s0_tag_r;
  logic                s0_err_r;
  logic                s1_valid_r;
  logic [TAG_W-1:0]    s1_tag_r;
  logic                s1_err_r;

  logic                push_s;
  logic                issue_s;
  logic                res_wr_s;
  logic                res_pop_s;
  logic [CRD_W-1:0]    credit_used_s;
  logic [31:0]         res_wr_data_s;
  logic [1:0]          inflight_s;

  assign inflight_s = {1'b0, s0_valid_r} + {1'b0, s1_valid_r};
  assign req_ready  = ready_en_r && (req_count_r != REQ_FULL_CNT);
  assign push_s     = req_valid && req_ready;
  assign res_wr_s   = s1_valid_r;
  assign rsp_valid  = (res_count_r != (RES_AW + 1)'(0));
  assign res_pop_s  = rsp_valid && rsp_ready;

  // Credit check counts in-flight ops against result FIFO space so a write never finds it full
  always_comb begin
    credit_used_s = CRD_W'(res_count_r) + CRD_W'(inflight_s);
    issue_s       = 1'b0;
    res_wr_data_s = fpu_out;
    if ((req_count_r != (REQ_AW + 1)'(0)) && (credit_used_s < RES_CREDITS)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    if (s1_err_r) begin
      res_wr_data_s = 32'h0000_0000;
    end else begin
      res_wr_data_s = fpu_out;
    end
  end

  // Request FIFO control: pointers, occupancy, and the post-reset ready enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_r   <= 1'b0;
      req_wr_ptr_r <= '0;
      req_rd_ptr_r <= '0;
      req_count_r  <= '0;
    end else begin
      ready_en_r <= 1'b1;
      if (push_s) req_wr_ptr_r <= req_wr_ptr_r + REQ_AW'(1);
      if (issue_s) req_rd_ptr_r <= req_rd_ptr_r + REQ_AW'(1);
      case ({push_s, issue_s})
        2'b10:   req_count_r <= req_count_r + (REQ_AW + 1)'(1);
        2'b01:   req_count_r <= req_count_r - (REQ_AW + 1)'(1);
        default: req_count_r <= req_count_r;
      endcase
    end
  end

  // Request FIFO storage (payload only, no reset needed)
  always_ff @(posedge clk) begin
    if (push_s) begin
      req_a_mem_r[req_wr_ptr_r]   <= req_a;
      req_b_mem_r[req_wr_ptr_r]   <= req_b;
      req_op_mem_r[req_wr_ptr_r]  <= req_op;
      req_tag_mem_r[req_wr_ptr_r] <= req_tag;
    end
  end

  // Issue registers toward the fpu and the two-stage shadow of its latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_a_r    <= 32'h0000_0000;
      fpu_b_r    <= 32'h0000_0000;
      fpu_op_r   <= 2'b00;
      s0_valid_r <= 1'b0;
      s0_tag_r   <= '0;
      s0_err_r   <= 1'b0;
      s1_valid_r <= 1'b0;
      s1_tag_r   <= '0;
      s1_err_r   <= 1'b0;
    end else begin
      if (issue_s) begin
        fpu_a_r  <= req_a_mem_r[req_rd_ptr_r];
        fpu_b_r  <= req_b_mem_r[req_rd_ptr_r];
        fpu_op_r <= req_op_mem_r[req_rd_ptr_r];
        s0_tag_r <= req_tag_mem_r[req_rd_ptr_r];
        s0_err_r <= (req_op_mem_r[req_rd_ptr_r] == OP_DIV);
      end
      s0_valid_r <= issue_s;
      s1_valid_r <= s0_valid_r;
      s1_tag_r   <= s0_tag_r;
      s1_err_r   <= s0_err_r;
    end
  end

  // Result FIFO control; write and pop may coincide at any occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_wr_ptr_r <= '0;
      res_rd_ptr_r <= '0;
      res_count_r  <= '0;
    end else begin
      if (res_wr_s) res_wr_ptr_r <= res_wr_ptr_r + RES_AW'(1);
      if (res_pop_s) res_rd_ptr_r <= res_rd_ptr_r + RES_AW'(1);
      case ({res_wr_s, res_pop_s})
        2'b10:   res_count_r <= res_count_r + (RES_AW + 1)'(1);
        2'b01:   res_count_r <= res_count_r - (RES_AW + 1)'(1);
        default: res_count_r <= res_count_r;
      endcase
    end
  end

  // Result FIFO storage; unsupported ops store zero data
  always_ff @(posedge clk) begin
    if (res_wr_s) begin
      res_data_mem_r[res_wr_ptr_r] <= res_wr_data_s;
      res_tag_mem_r[res_wr_ptr_r]  <= s1_tag_r;
      res_err_mem_r[res_wr_ptr_r]  <= s1_err_r;
    end
  end

  assign fpu_a    = fpu_a_r;
  assign fpu_b    = fpu_b_r;
  assign fpu_op   = fpu_op_r;
  assign inflight = inflight_s;
  assign rsp_data = res_data_mem_r[res_rd_ptr_r];
  assign rsp_tag  = res_tag_mem_r[res_rd_ptr_r];
  assign rsp_err  = res_err_mem_r[res_rd_ptr_r];

endmodule

// File: tb/tb_fpu_req_sequencer.sv
// Directed bench for fpu_req_sequencer with a small registered fpu model on small-integer floats.
module tb_fpu_req_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  req_op;
  logic [3:0]  req_tag;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_out = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic [1:0]  inflight;

  int n_cmp = 0;
  int n_err = 0;
  int acc;

  fpu_req_sequencer #(.REQ_DEPTH(4), .RES_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_out(fpu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  // IEEE-754 single encodings of 0.0 .. 10.0
  function automatic logic [31:0] flt(input int k);
    case (k)
      0: flt = 32'h0000_0000;   1: flt = 32'h3F80_0000;   2: flt = 32'h4000_0000;
      3: flt = 32'h4040_0000;   4: flt = 32'h4080_0000;   5: flt = 32'h40A0_0000;
      6: flt = 32'h40C0_0000;   7: flt = 32'h40E0_0000;   8: flt = 32'h4100_0000;
      9: flt = 32'h4110_0000;  10: flt = 32'h4120_0000;
      default: flt = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic int idx(input logic [31:0] v);
    for (int k = 0; k <= 10; k++) if (flt(k) == v) return k;
    return -1;
  endfunction

  function automatic logic [31:0] fpu_calc(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    int x, y, r;
    x = idx(a);
    y = idx(b);
    if (op == 2'b11) return 32'hDEAD_BEEF;
    if (x < 0 || y < 0) return 32'hFFFF_FFFF;
    case (op)
      2'b00:   r = x + y;
      2'b01:   r = x - y;
      default: r = x * y;
    endcase
    if (r < 0 || r > 10) return 32'hFFFF_FFFF;
    return flt(r);
  endfunction

  // fpu model: one-cycle registered result
  always @(posedge clk) fpu_out <= fpu_calc(fpu_a, fpu_b, fpu_op);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present one request until accepted (bounded); returns at the negedge after the accepting edge
  task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input logic [3:0] tag);
    logic ok;
    logic r;
    ok = 1'b0;
    req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
    for (int c = 0; c < 10 && !ok; c++) begin
      r = req_ready;
      step();
      ok = r;
    end
    req_valid = 1'b0;
    check("offer_accept", 32'(ok), 32'd1);
  endtask

  // Offer ADD 1.0+k with tag k for k=0..9 while results are blocked; returns count accepted
  task automatic fill(output int accepted);
    int i;
    logic r;
    i = 0;
    for (int c = 0; c < 30 && i < 10; c++) begin
      req_a = flt(1); req_b = flt(i); req_op = 2'b00; req_tag = 4'(i); req_valid = 1'b1;
      r = req_ready;
      step();
      if (r) i++;
    end
    req_valid = 1'b0;
    accepted = i;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_a = 32'h0; req_b = 32'h0; req_op = 2'b00;
    req_tag = 4'h0; rsp_ready = 1'b0;
    step(); step();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_fpu_a", fpu_a, 32'h0);
    check("rst_fpu_op", 32'(fpu_op), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // single ADD, 3-cycle latency
    offer(flt(1), flt(2), 2'b00, 4'd5);
    check("add_t0_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    check("add_t1_fpu_op", 32'(fpu_op), 32'd0);
    check("add_t1_fpu_a", fpu_a, 32'h3F80_0000);
    check("add_t1_fpu_b", fpu_b, 32'h4000_0000);
    check("add_t1_inflight", 32'(inflight), 32'd1);
    step();
    check("add_t2_rsp_valid", 32'(rsp_valid), 32'd0);
    check("add_t2_inflight", 32'(inflight), 32'd1);
    step();
    check("add_t3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("add_t3_rsp_data", rsp_data, 32'h4040_0000);
    check("add_t3_rsp_tag", 32'(rsp_tag), 32'd5);
    check("add_t3_rsp_err", 32'(rsp_err), 32'd0);
    check("add_t3_inflight", 32'(inflight), 32'd0);
    rsp_ready = 1'b1;
    step();
    check("add_popped", 32'(rsp_valid), 32'd0);

    // back-to-back SUB then MUL
    offer(flt(3), flt(1), 2'b01, 4'd1);
    offer(flt(2), flt(3), 2'b10, 4'd2);
    check("b2b_inflight1", 32'(inflight), 32'd1);
    step();
    check("b2b_inflight2", 32'(inflight), 32'd2);
    step();
    check("b2b_r1_valid", 32'(rsp_valid), 32'd1);
    check("b2b_r1_data", rsp_data, 32'h4000_0000);
    check("b2b_r1_tag", 32'(rsp_tag), 32'd1);
    step();
    check("b2b_r2_valid", 32'(rsp_valid), 32'd1);
    check("b2b_r2_data", rsp_data, 32'h40C0_0000);
    check("b2b_r2_tag", 32'(rsp_tag), 32'd2);
    step();
    check("b2b_drained", 32'(rsp_valid), 32'd0);

    // unsupported DIV
    offer(flt(4), flt(2), 2'b11, 4'd7);
    step(); step(); step();
    check("div_valid", 32'(rsp_valid), 32'd1);
    check("div_data", rsp_data, 32'h0000_0000);
    check("div_err", 32'(rsp_err), 32'd1);
    check("div_tag", 32'(rsp_tag), 32'd7);
    step();
    check("div_popped", 32'(rsp_valid), 32'd0);

    // backpressure fill
    rsp_ready = 1'b0;
    fill(acc);
    check("bp_accepted", 32'(acc), 32'd8);
    check("bp_req_ready", 32'(req_ready), 32'd0);
    check("bp_inflight", 32'(inflight), 32'd0);
    for (int k = 0; k < 3; k++) begin
      check("bp_stable_valid", 32'(rsp_valid), 32'd1);
      check("bp_stable_tag", 32'(rsp_tag), 32'd0);
      check("bp_stable_data", rsp_data, flt(1));
      check("bp_stable_err", 32'(rsp_err), 32'd0);
      step();
    end

    // drain in order; pop and issue coincide at the second edge
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain_valid", 32'(rsp_valid), 32'd1);
      check("drain_tag", 32'(rsp_tag), 32'(k));
      check("drain_data", rsp_data, flt(k + 1));
      if (k == 2) begin
        check("pop_issue_inflight", 32'(inflight), 32'd1);
        check("pop_issue_fpu_b", fpu_b, flt(4));
      end
      step();
    end
    check("drain_empty", 32'(rsp_valid), 32'd0);
    check("drain_inflight", 32'(inflight), 32'd0);

    // reset mid-operation with 2 in flight and 3 queued
    rsp_ready = 1'b0;
    fill(acc);
    check("rst_fill_accepted", 32'(acc), 32'd8);
    rsp_ready = 1'b1;
    req_a = flt(1); req_b = flt(8); req_op = 2'b00; req_tag = 4'd8; req_valid = 1'b1;
    step(); step(); step();
    req_valid = 1'b0;
    check("pre_rst_inflight", 32'(inflight), 32'd2);
    check("pre_rst_req_ready", 32'(req_ready), 32'd1);
    check("pre_rst_rsp_tag", 32'(rsp_tag), 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_inflight", 32'(inflight), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_fpu_a", fpu_a, 32'h0);
    check("mid_rst_fpu_op", 32'(fpu_op), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("rel_req_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("no_stale_rsp", 32'(rsp_valid), 32'd0);
      step();
    end
    offer(flt(1), flt(2), 2'b00, 4'd9);
    step(); step();
    check("post_rst_t2_valid", 32'(rsp_valid), 32'd0);
    step();
    check("post_rst_t3_valid", 32'(rsp_valid), 32'd1);
    check("post_rst_t3_data", rsp_data, 32'h4040_0000);
    check("post_rst_t3_tag", 32'(rsp_tag), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_req_sequencer.md
Name: fpu_req_sequencer

Overview:
Front-end issue stage that sits directly upstream of the fpu datapath. It accepts tagged operation requests over a valid/ready interface and buffers them in a request FIFO. It drives registered operands and opcode into the fpu, tracks the fpu's one-cycle registered result latency, and delivers in-order tagged results through a result FIFO with valid/ready backpressure. A credit check guarantees no in-flight result is ever dropped.

Parameters:
REQ_DEPTH, 4, request FIFO entries; power of 2, minimum 2.
RES_DEPTH, 4, result FIFO entries; power of 2, minimum 2.
TAG_W, 4, width of the request/response tag.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset; asynchronous, active-low.
req_valid  in  1  request present.
req_ready  out  1  request FIFO can accept.
req_a  in  32  operand A, IEEE-754 single.
req_b  in  32  operand B, IEEE-754 single.
req_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV (unsupported).
req_tag  in  TAG_W  opaque ID, returned with the result.
fpu_a  out  32  registered operand A to the fpu.
fpu_b  out  32  registered operand B to the fpu.
fpu_op  out  2  registered opcode to the fpu.
fpu_out  in  32  registered result from the fpu.
rsp_valid  out  1  result available.
rsp_ready  in  1  consumer accepts the result.
rsp_data  out  32  result value.
rsp_tag  out  TAG_W  tag of the matching request.
rsp_err  out  1  1 if the request opcode was 11.
inflight  out  2  number of issued ops not yet written to the result FIFO (0..2).

Behaviour:
- Reset (rst_n low, asynchronous):
  - Clear both FIFO pointers and counts, and both pipeline valid bits.
  - fpu_a, fpu_b and fpu_op go to 0.
  - rsp_valid=0, inflight=0, req_ready=0 while rst_n is low.
  - req_ready=1 from the first edge after release.
  - Reset mid-operation discards all queued and in-flight ops; no partial response appears afterwards.
- Request FIFO:
  - req_ready = !req_full.
  - A push occurs when req_valid && req_ready at the clock edge.
  - When full, no push is accepted, even if a pop happens in the same cycle.
  - Pointers wrap modulo REQ_DEPTH.
- Issue condition: req FIFO not empty AND (res_count + inflight) < RES_DEPTH.
- On issue at edge t:
  - fpu_a, fpu_b, fpu_op <= head entry; pop the head.
  - s0_valid <= 1, with tag and err = (op==2'b11) carried alongside.
- When not issuing: fpu_a, fpu_b and fpu_op hold their last values; s0_valid <= 0.
- Pipeline timing:
  - s1 <= s0 at each edge. s1 models the fpu capturing its result at edge t+1.
  - At edge t+2, when s1_valid is set, write {fpu_out, s1_tag, s1_err} into the result FIFO.
  - When s1_err is set, force the stored data to 32'h0.
- inflight = s0_valid + s1_valid.
- Latency: a request accepted at edge t into an empty system issues at t+1 and is written at t+3. rsp_valid is high after edge t+3, three cycles total. Back-to-back issue gives one result per cycle.
- Result FIFO:
  - Show-ahead: rsp_valid = !res_empty; rsp_data, rsp_tag and rsp_err come from the head.
  - A pop occurs on rsp_valid && rsp_ready.
  - A write and a pop in the same cycle are allowed at any occupancy, including full.
  - The credit rule guarantees a write never targets a full FIFO.
- Ordering: responses leave strictly in request order.
- rsp_* outputs must remain stable while rsp_valid && !rsp_ready.

Test Plan:
- Reset, then ADD 0x3F800000 + 0x40000000 with tag 5 at edge t -> fpu_op=00 after t+1; rsp_valid=1 after t+3; rsp_data=0x40400000, rsp_tag=5, rsp_err=0.
- Back-to-back: SUB 0x40400000 - 0x3F800000 (tag 1), then MUL 0x40000000 * 0x40400000 (tag 2) -> consecutive responses 0x40000000/tag 1, then 0x40C00000/tag 2; inflight reaches 2.
- DIV op 11, A=0x40800000, B=0x40000000, tag 7 -> rsp_data=0x00000000, rsp_err=1, rsp_tag=7.
- Backpressure: rsp_ready=0, offer 10 ADDs (tags 0..9) -> exactly 4 issued; result FIFO full; req FIFO holds 4; req_ready=0; inflight=0; rsp_* stable. Raise rsp_ready -> all 8 accepted ops return in tag order 0..7, one per cycle once streaming.
- Simultaneous events: result FIFO full with rsp_ready=1 and a pending request -> pop and issue in the same cycle, with no loss or duplication.
- Assert rst_n low with 2 in flight and 3 queued -> rsp_valid=0 immediately and inflight=0; after release, no stale response; a new ADD completes with 3-cycle latency.
